// File: rtl/sims_spi_main.sv
// sims_spi_main: host-triggered SPI burst sequencer that issues N command frames,
// captures one MISO word per frame and streams each capture to a downstream FIFO.
module sims_spi_main #(
   parameter int DATA_W          = 16,
   parameter int MAX_FRAMES_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ep00wirein,
   input  logic [31:0] ep01wirein,
   input  logic [31:0] ep02wirein,
   input  logic [31:0] ep03wirein,
   input  logic [31:0] ep04wirein,
   input  logic [31:0] ep05wirein,
   input  logic [31:0] ep40trigin,
   input  logic [31:0] ep41trigin,
   output logic [31:0] ep22wireout,
   output logic [31:0] ep24wireout,
   output logic        MOSI_to_sensor,
   input  logic        MISO_from_sensor,
   output logic        SCLK_wire,
   output logic        CS_b_wire,
   output logic [31:0] fpgaout_fifoin_din,
   output logic        fpgaout_fifoin_wr_en
);
   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, DONE} state_t;
   typedef struct packed {
      logic [DATA_W-1:0]          cmd;
      logic [DATA_W-1:0]          tx;
      logic [DATA_W-1:0]          sh;
      logic [7:0]                 div;
      logic [7:0]                 gap;
      logic                       auto_inc;
      logic [MAX_FRAMES_LOG2-1:0] n_m1;
      logic [7:0]                 tmr;
      logic [3:0]                 bitn;
      logic                       ph;
      logic [7:0]                 frames;
      logic [7:0]                 last_idx;
      logic [DATA_W-1:0]          last_word;
      logic [15:0]                burst;
      logic                       busy;
      logic                       done;
      logic                       wr_en;
   } regs_t;
   state_t state, state_d;
   regs_t  r, rn;
   logic start, abort, t_end;
   logic [7:0] g_len, h_ld, t_ld;
   logic unused_ok;
   assign unused_ok = ^{ep00wirein[31:1], ep01wirein[31:16], ep02wirein[31:8], ep03wirein[31:8],
                        ep04wirein[31:1], ep05wirein[31:MAX_FRAMES_LOG2], ep40trigin[31:1], ep41trigin[31:1]};
   assign start = ep41trigin[0];
   assign abort = ep40trigin[0];
   assign t_end = r.tmr == 8'd0;
   assign g_len = (r.gap < 8'd2) ? 8'd2 : r.gap;
   // Timings must come from the wire-ins on the very clk that a burst starts.
   assign h_ld  = (state == IDLE) ? ep02wirein[7:0] : r.div;
   assign t_ld  = (state_d == GAP) ? g_len - 8'd1 : h_ld;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         r     <= '0;
      end else if (ep00wirein[0]) begin
         state <= IDLE;
         r     <= '0;
      end else begin
         state <= state_d;
         r     <= rn;
      end
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = start ? LEAD : IDLE;
         LEAD:    state_d = t_end ? SHIFT : LEAD;
         SHIFT:   state_d = (t_end && r.ph && r.bitn == 4'(DATA_W - 1)) ? GAP : SHIFT;
         GAP:     state_d = t_end ? ((r.frames <= {{(8-MAX_FRAMES_LOG2){1'b0}}, r.n_m1}) ? LEAD : DONE) : GAP;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state != IDLE) state_d = IDLE;
   end
   always_comb begin
      rn       = r;
      rn.wr_en = 1'b0;
      rn.tmr   = (state_d != state || t_end) ? t_ld : r.tmr - 8'd1;
      if (state == IDLE && state_d == LEAD) begin
         rn.cmd      = ep01wirein[DATA_W-1:0];
         rn.div      = ep02wirein[7:0];
         rn.gap      = ep03wirein[7:0];
         rn.auto_inc = ep04wirein[0];
         rn.n_m1     = ep05wirein[MAX_FRAMES_LOG2-1:0];
         rn.busy     = 1'b1;
         rn.done     = 1'b0;
         rn.frames   = 8'd0;
         rn.burst    = r.burst + 16'd1;
      end
      if (state_d == LEAD && state != LEAD) begin
         rn.tx   = (state == IDLE) ? ep01wirein[DATA_W-1:0] : r.cmd;
         rn.ph   = 1'b0;
         rn.bitn = 4'd0;
      end
      // ph=0 is the SCLK-high half; its last clk samples MISO and advances MOSI.
      if (state == SHIFT && t_end) begin
         rn.ph   = !r.ph;
         rn.bitn = r.ph ? r.bitn + 4'd1 : r.bitn;
         if (!r.ph) begin
            rn.sh = {r.sh[DATA_W-2:0], MISO_from_sensor};
            rn.tx = r.tx << 1;
         end
      end
      if (state == SHIFT && state_d == GAP) begin
         rn.last_word = r.sh;
         rn.last_idx  = r.frames;
         rn.frames    = r.frames + 8'd1;
         rn.wr_en     = 1'b1;
         if (r.auto_inc) rn.cmd[13:8] = r.cmd[13:8] + 6'd1;
      end
      if (state_d == DONE) begin
         rn.busy = 1'b0;
         rn.done = 1'b1;
      end
      if (abort && state != IDLE) begin
         rn.busy = 1'b0;
         rn.done = 1'b0;
      end
   end
   assign SCLK_wire            = state == SHIFT && !r.ph;
   assign CS_b_wire            = !(state == LEAD || state == SHIFT);
   assign MOSI_to_sensor       = !CS_b_wire && r.tx[DATA_W-1];
   assign ep22wireout          = {8'd0, r.last_idx, r.last_word};
   assign ep24wireout          = {r.burst, r.frames, 6'd0, r.done, r.busy};
   assign fpgaout_fifoin_din   = ep22wireout;
   assign fpgaout_fifoin_wr_en = r.wr_en;
endmodule

// File: tb/tb_sims_spi_main.sv
// tb_sims_spi_main: directed bench for the SPI burst sequencer with a mode-0 sensor model.
module tb_sims_spi_main;
   logic        clk = 0, reset = 1;
   logic [31:0] ep00 = 0, ep01 = 0, ep02 = 0, ep03 = 0, ep04 = 0, ep05 = 0, ep40 = 0, ep41 = 0;
   logic [31:0] ep22, ep24, din;
   logic        mosi, miso, sclk, cs_b, wr_en;
   int n_checks = 0, n_fail = 0;
   sims_spi_main dut (
      .clk(clk), .reset(reset),
      .ep00wirein(ep00), .ep01wirein(ep01), .ep02wirein(ep02), .ep03wirein(ep03),
      .ep04wirein(ep04), .ep05wirein(ep05), .ep40trigin(ep40), .ep41trigin(ep41),
      .ep22wireout(ep22), .ep24wireout(ep24),
      .MOSI_to_sensor(mosi), .MISO_from_sensor(miso), .SCLK_wire(sclk), .CS_b_wire(cs_b),
      .fpgaout_fifoin_din(din), .fpgaout_fifoin_wr_en(wr_en)
   );
   always #5 clk = ~clk;
   // Sensor presents bit 15 when selected and shifts on each falling SCLK.
   logic [15:0] miso_word = 16'h1234, miso_sr = 16'h0;
   always @(negedge cs_b) miso_sr = miso_word;
   always @(negedge sclk) if (!cs_b) miso_sr = {miso_sr[14:0], 1'b0};
   assign miso = miso_sr[15];
   logic [31:0] din_q[$];
   logic [15:0] mosi_q[$];
   int fall_q[$], gap_q[$], hi_q[$];
   int cyc = 0, hi = 0, ch = 0;
   logic [15:0] mw = 0;
   logic pcs = 1, psclk = 0;
   always @(negedge clk) begin
      cyc++;
      if (wr_en) din_q.push_back(din);
      if (!cs_b && pcs) begin
         fall_q.push_back(cyc);
         gap_q.push_back(ch);
         mw = 0;
      end
      if (cs_b && !pcs) mosi_q.push_back(mw);
      ch = cs_b ? ((!pcs) ? 1 : ch + 1) : ch;
      if (sclk && !psclk) mw = {mw[14:0], mosi};
      if (sclk) hi++;
      else if (psclk) begin
         hi_q.push_back(hi);
         hi = 0;
      end
      pcs   = cs_b;
      psclk = sclk;
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic pulse(input logic s, input logic a);
      @(negedge clk);
      ep41[0] = s;
      ep40[0] = a;
      @(negedge clk);
      ep41 = 0;
      ep40 = 0;
   endtask
   task automatic wait_done(input string tag);
      for (int i = 0; i < 20000 && !ep24[1]; i++) @(negedge clk);
      check(tag, 32'(ep24[1]), 1);
   endtask
   task automatic wait_wr(input string tag, input int n);
      for (int i = 0; i < 2000 && din_q.size() < n; i++) @(negedge clk);
      check(tag, 32'(din_q.size() >= n), 1);
   endtask
   initial begin
      int b, fb, mb, hb, bad;
      #2 reset = 0;
      #1;
      check("rst_cs", 32'(cs_b), 1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_mosi", 32'(mosi), 0);
      check("rst_ep22", ep22, 0);
      check("rst_ep24", ep24, 0);
      check("rst_wr", 32'(wr_en), 0);
      repeat (3) @(negedge clk);
      reset = 1;
      ep00 = 1;
      pulse(1, 0);
      check("srst_ep24", ep24, 0);
      check("srst_cs", 32'(cs_b), 1);
      ep00 = 0;
      @(negedge clk);
      check("post_srst_ep24", ep24, 0);
      // 32 frames, default timing
      ep05 = 31; ep01 = 32'hA5C3;
      b = din_q.size(); fb = fall_q.size(); mb = mosi_q.size();
      pulse(1, 0);
      check("t2_busy", 32'(ep24[0]), 1);
      wait_done("t2_done");
      check("t2_wr_cnt", din_q.size() - b, 32);
      check("t2_ep24", ep24, 32'h0001_2002);
      check("t2_ep22", ep22, {16'd31, 16'h1234});
      check("t2_mosi", 32'(mosi_q[mb]), 32'hA5C3);
      check("t2_period", fall_q[fb+1] - fall_q[fb], 35);
      bad = 0;
      for (int i = 0; i < 32; i++) if (din_q[b+i] !== {16'(i), 16'h1234}) bad++;
      check("t2_din", bad, 0);
      // 6 frames, different MISO pattern
      miso_word = 16'h8001; ep05 = 5;
      b = din_q.size();
      pulse(1, 0);
      wait_done("t3_done");
      check("t3_wr_cnt", din_q.size() - b, 6);
      check("t3_ep22", ep22, {16'd5, 16'h8001});
      check("t3_ep24", ep24, 32'h0002_0602);
      // slow SCLK, long gap, auto-increment wrap
      miso_word = 16'h1234; ep02 = 3; ep03 = 10; ep04 = 1; ep01 = 32'h3F00; ep05 = 1;
      fb = fall_q.size(); mb = mosi_q.size(); hb = hi_q.size();
      pulse(1, 0);
      wait_done("t4_done");
      check("t4_period", fall_q[fb+1] - fall_q[fb], 142);
      check("t4_cs_high", gap_q[fb+1], 10);
      check("t4_sclk_high", hi_q[hb], 4);
      check("t4_mosi0", 32'(mosi_q[mb]), 32'h3F00);
      check("t4_mosi1", 32'(mosi_q[mb+1]), 32'h0000);
      check("t4_ep22", ep22, {16'd1, 16'h1234});
      check("t4_ep24", ep24, 32'h0003_0202);
      // ignored restart, then abort during the fourth frame
      ep02 = 0; ep03 = 0; ep04 = 0; ep01 = 32'h00FF; ep05 = 7;
      b = din_q.size();
      pulse(1, 0);
      wait_wr("t5_wait1", b + 1);
      pulse(1, 0);
      check("t5_burst_kept", 32'(ep24[31:16]), 4);
      check("t5_busy_kept", 32'(ep24[0]), 1);
      wait_wr("t5_wait3", b + 3);
      repeat (10) @(negedge clk);
      check("t5_cs_pre", 32'(cs_b), 0);
      pulse(0, 1);
      check("t5_cs", 32'(cs_b), 1);
      check("t5_sclk", 32'(sclk), 0);
      check("t5_ep24", ep24, 32'h0004_0300);
      repeat (100) @(negedge clk);
      check("t5_wr_cnt", din_q.size() - b, 3);
      // start and abort together in IDLE, then async reset mid-burst
      pulse(1, 1);
      check("t6_busy", 32'(ep24[0]), 1);
      check("t6_burst", 32'(ep24[31:16]), 5);
      repeat (20) @(negedge clk);
      check("t6_cs_pre", 32'(cs_b), 0);
      #2 reset = 0;
      #1;
      check("t6_rst_cs", 32'(cs_b), 1);
      check("t6_rst_sclk", 32'(sclk), 0);
      check("t6_rst_ep24", ep24, 0);
      check("t6_rst_ep22", ep22, 0);
      @(negedge clk);
      reset = 1;
      repeat (5) @(negedge clk);
      check("t6_idle_cs", 32'(cs_b), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
